// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier operand sequencer.
// State encoding matches the controller handshake slots.
package mul_pkg;

    localparam int MUL_W       = 16;
    localparam int MUL_TMO_CYC = 1023;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        LOAD_A = 3'd2,
        LOAD_B = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } mul_state_e;

endpackage

// File: rtl/mul_edge_det.sv
// Registers the multiplier done level and flags its rising edge.
// The pulse is combinational from the live level and the registered copy.
module mul_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/mul_operand_seq.sv
// Front-end sequencer for the repeated-addition multiplier.
// Optional WAIT watchdog enabled by defining MULSEQ_TIMEOUT_EN.
module mul_operand_seq
    import mul_pkg::*;
#(
    parameter int W       = MUL_W,
    parameter int TMO_CYC = MUL_TMO_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         mul_start,
    output logic [W-1:0] mul_data,
    input  logic         mul_done,
    input  logic [W-1:0] mul_prod,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_prod,
    output logic         out_err
);

    mul_state_e   state, state_n;
    logic [W-1:0] a_q, b_q;
    logic [W-1:0] a_n, b_n;
    logic [W-1:0] prod_n;
    logic [W-1:0] data_n;
    logic         err_q, err_n;
    logic         done_rise;
    logic         tmo_hit;
    logic         hs_in, hs_out;

    assign hs_in   = in_valid && in_ready;
    assign hs_out  = out_valid && out_ready;
    assign out_err = err_q;

    mul_edge_det u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (mul_done),
        .rise (done_rise)
    );

`ifdef MULSEQ_TIMEOUT_EN
    logic [W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == WAIT) && (tmo_cnt == W'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        prod_n  = out_prod;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (hs_in) begin
                    a_n = in_a;
                    b_n = in_b;
                    // A zero loop count breaks the multiplier, so bypass it
                    if (in_a == '0 || in_b == '0) begin
                        state_n = RESP;
                        prod_n  = '0;
                        err_n   = 1'b0;
                    end else begin
                        state_n = START;
                    end
                end
            end
            START:  state_n = LOAD_A;
            LOAD_A: state_n = LOAD_B;
            LOAD_B: state_n = WAIT;
            WAIT: begin
                if (done_rise) begin
                    state_n = RESP;
                    prod_n  = mul_prod;
                    err_n   = 1'b0;
                end else if (tmo_hit) begin
                    state_n = RESP;
                    prod_n  = '0;
                    err_n   = 1'b1;
                end
            end
            RESP: begin
                if (hs_out) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        data_n = '0;
        unique case (state_n)
            START, LOAD_A: data_n = a_n;
            LOAD_B, WAIT:  data_n = b_n;
            default:       data_n = '0;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b0;
            mul_start <= 1'b0;
            mul_data  <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            a_q       <= a_n;
            b_q       <= b_n;
            in_ready  <= (state_n == IDLE) && !mul_done;
            mul_start <= (state_n == START);
            mul_data  <= data_n;
            out_valid <= (state_n == RESP);
            out_prod  <= prod_n;
            err_q     <= err_n;
        end
    end

endmodule
